// File: rtl/rom_dump_sequencer_if.sv
// Control, cartridge-bus and UART-handshake signals of the ROM dump sequencer.
interface rom_dump_sequencer_if #(
  parameter int unsigned ADDR_W = 15
) ();
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rd;
  logic [7:0]        bus_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_done;
  logic              busy;
  logic              finished;
  logic [ADDR_W:0]   bytes_sent;

  modport slave (
    input  start, abort, start_addr, length, bus_data, tx_done,
    output bus_addr, bus_rd, tx_data, tx_valid, busy, finished, bytes_sent
  );

  modport master (
    output start, abort, start_addr, length, bus_data, tx_done,
    input  bus_addr, bus_rd, tx_data, tx_valid, busy, finished, bytes_sent
  );
endinterface

// File: rtl/rom_dump_sequencer.sv
// Walks a cartridge address range, samples each byte after a settle time and
// streams it to the UART, optionally followed by an additive checksum byte.
module rom_dump_sequencer #(
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter bit          CHECKSUM_EN   = 1'b1
) (
  input logic                 CLOCK_50,
  input logic                 RESET,
  rom_dump_sequencer_if.slave bus
);
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT_TX, S_SEND, S_GUARD, S_TRAILER, S_DONE
  } state_t;

  state_t            r_state;
  logic              r_start_q;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [LEN_W-1:0]  r_bytes_sent;
  logic [CNT_W-1:0]  r_settle_cnt;
  logic              r_guard_cnt;
  logic [7:0]        r_byte;
  logic [7:0]        r_checksum;
  logic [7:0]        r_tx_data;
  logic              r_bus_rd;
  logic              r_tx_valid;
  logic              r_busy;
  logic              r_finished;
  logic              r_trailer;
  logic              w_start_edge;

  assign w_start_edge = bus.start & ~r_start_q;

  always_ff @(posedge CLOCK_50) begin
    r_start_q  <= bus.start;
    r_tx_valid <= 1'b0;
    r_finished <= 1'b0;
    if (RESET) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_bus_addr   <= '0;
      r_remaining  <= '0;
      r_bytes_sent <= '0;
      r_settle_cnt <= '0;
      r_guard_cnt  <= 1'b0;
      r_byte       <= '0;
      r_checksum   <= '0;
      r_tx_data    <= '0;
      r_bus_rd     <= 1'b0;
      r_busy       <= 1'b0;
      r_trailer    <= 1'b0;
    end else if (bus.abort) begin
      // abort beats any pending send or start edge; counts are kept
      r_state  <= S_IDLE;
      r_bus_rd <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_addr       <= bus.start_addr;
            r_remaining  <= bus.length;
            r_checksum   <= '0;
            r_bytes_sent <= '0;
            r_trailer    <= 1'b0;
            r_busy       <= 1'b1;
            if (bus.length == '0) begin
              if (CHECKSUM_EN) begin
                r_state <= S_TRAILER;
              end else begin
                r_state    <= S_DONE;
                r_finished <= 1'b1;
              end
            end else begin
              r_state      <= S_SETTLE;
              r_bus_addr   <= bus.start_addr;
              r_bus_rd     <= 1'b1;
              r_settle_cnt <= '0;
            end
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_byte  <= bus.bus_data;
            r_state <= S_WAIT_TX;
          end else begin
            r_settle_cnt <= r_settle_cnt + CNT_W'(1);
          end
        end
        S_WAIT_TX: begin
          if (bus.tx_done) begin
            r_state      <= S_SEND;
            r_tx_valid   <= 1'b1;
            r_tx_data    <= r_byte;
            r_checksum   <= r_checksum + r_byte;
            r_bytes_sent <= r_bytes_sent + LEN_W'(1);
            r_remaining  <= r_remaining - LEN_W'(1);
            r_addr       <= r_addr + ADDR_W'(1);
          end
        end
        S_TRAILER: begin
          if (bus.tx_done) begin
            r_state    <= S_SEND;
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_checksum;
            r_trailer  <= 1'b1;
          end
        end
        S_SEND: begin
          r_state     <= S_GUARD;
          r_guard_cnt <= 1'b0;
        end
        S_GUARD: begin
          // two cycles for the UART to drop tx_done before it is looked at again
          if (r_guard_cnt) begin
            if (r_trailer) begin
              r_state    <= S_DONE;
              r_finished <= 1'b1;
            end else if (r_remaining == '0) begin
              r_bus_rd <= 1'b0;
              if (CHECKSUM_EN) begin
                r_state <= S_TRAILER;
              end else begin
                r_state    <= S_DONE;
                r_finished <= 1'b1;
              end
            end else begin
              r_state      <= S_SETTLE;
              r_bus_addr   <= r_addr;
              r_settle_cnt <= '0;
            end
          end else begin
            r_guard_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_bus_rd <= 1'b0;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_bus_rd <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_addr   = r_bus_addr;
  assign bus.bus_rd     = r_bus_rd;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.busy       = r_busy;
  assign bus.finished   = r_finished;
  assign bus.bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Scoreboard bench: two sequencers (with and without checksum trailer) in lockstep
// against a memory model, a UART busy model and a byte-stream reference model.
module tb_rom_dump_sequencer;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned SETTLE = 8;
  localparam int unsigned MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  logic [7:0]        bus_data;
  logic              tx_done;

  rom_dump_sequencer_if #(.ADDR_W(ADDR_W)) if0 ();
  rom_dump_sequencer_if #(.ADDR_W(ADDR_W)) if1 ();

  assign if0.start = start;      assign if1.start = start;
  assign if0.abort = abort;      assign if1.abort = abort;
  assign if0.start_addr = start_addr; assign if1.start_addr = start_addr;
  assign if0.length = length;    assign if1.length = length;
  assign if0.bus_data = bus_data; assign if1.bus_data = bus_data;
  assign if0.tx_done = tx_done;  assign if1.tx_done = tx_done;

  rom_dump_sequencer #(.ADDR_W(ADDR_W), .SETTLE_CYCLES(SETTLE), .CHECKSUM_EN(1'b1)) dut0 (
    .CLOCK_50(clk), .RESET(rst), .bus(if0));
  rom_dump_sequencer #(.ADDR_W(ADDR_W), .SETTLE_CYCLES(SETTLE), .CHECKSUM_EN(1'b0)) dut1 (
    .CLOCK_50(clk), .RESET(rst), .bus(if1));

  always #10 clk = ~clk;

  logic [7:0]        mem [MEM_N];
  logic [7:0]        exp_q0 [$];
  logic [7:0]        exp_q1 [$];
  logic [ADDR_W-1:0] addr_log [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fin0 = 0, fin1 = 0;
  int last_tx0 = 0, last_tx1 = 0;
  int age = 0;
  int hold_left = 0;
  int uart_hold = 10;
  logic prev_txv0 = 1'b0, prev_txv1 = 1'b0;
  logic prev_rd = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  bit rd_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor, UART busy model and cartridge memory model, all 1 time unit past the edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      if (if0.tx_valid) begin
        chk("dut0_txv_gap", 32'(prev_txv0), 0);
        chk("dut0_txdone_before", 32'(tx_done), 1);
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL dut0_unexpected_tx: got 0x%0h expected no byte", if0.tx_data);
        end else chk("dut0_tx_data", 32'(if0.tx_data), 32'(exp_q0.pop_front()));
        last_tx0 = cyc;
      end
      if (if1.tx_valid) begin
        chk("dut1_txv_gap", 32'(prev_txv1), 0);
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL dut1_unexpected_tx: got 0x%0h expected no byte", if1.tx_data);
        end else chk("dut1_tx_data", 32'(if1.tx_data), 32'(exp_q1.pop_front()));
        last_tx1 = cyc;
      end
      if (if0.finished) begin
        fin0++;
        if (last_tx0 > 0) chk("dut0_fin_latency", 32'(cyc - last_tx0), 3);
      end
      if (if1.finished) begin
        fin1++;
        if (last_tx1 > 0) chk("dut1_fin_latency", 32'(cyc - last_tx1), 3);
      end
      if (if0.bus_rd) rd_seen = 1'b1;
    end
    prev_txv0 = if0.tx_valid;
    prev_txv1 = if1.tx_valid;
    if (if0.tx_valid || if1.tx_valid) begin
      tx_done = 1'b0;
      hold_left = uart_hold;
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) tx_done = 1'b1;
    end
    if (if0.bus_rd && (!prev_rd || if0.bus_addr != prev_addr)) age = 1;
    else age++;
    prev_rd = if0.bus_rd;
    prev_addr = if0.bus_addr;
    // valid data only in the last settle cycle, so early or late sampling is caught
    if (if0.bus_rd && age == int'(SETTLE)) begin
      bus_data = mem[if0.bus_addr];
      addr_log.push_back(if0.bus_addr);
    end else begin
      bus_data = ~mem[if0.bus_addr];
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_dut0_bus_addr"}, 32'(if0.bus_addr), 0);
    chk({tag, "_dut0_bus_rd"}, 32'(if0.bus_rd), 0);
    chk({tag, "_dut0_tx_data"}, 32'(if0.tx_data), 0);
    chk({tag, "_dut0_tx_valid"}, 32'(if0.tx_valid), 0);
    chk({tag, "_dut0_busy"}, 32'(if0.busy), 0);
    chk({tag, "_dut0_finished"}, 32'(if0.finished), 0);
    chk({tag, "_dut0_bytes_sent"}, 32'(if0.bytes_sent), 0);
    chk({tag, "_dut1_busy"}, 32'(if1.busy), 0);
    chk({tag, "_dut1_bytes_sent"}, 32'(if1.bytes_sent), 0);
  endtask

  task automatic wait_fin(input int t0, input int t1, input int budget);
    int n;
    n = 0;
    while ((fin0 < t0 || fin1 < t1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("dump_completes_in_time", 32'(fin0 >= t0 && fin1 >= t1), 1);
  endtask

  task automatic do_dump(input logic [ADDR_W-1:0] a, input int len, input int hold);
    logic [7:0]        sum;
    logic [ADDR_W-1:0] ad;
    int f0, f1;
    sum = 8'h00;
    uart_hold = hold;
    last_tx0 = 0;
    last_tx1 = 0;
    rd_seen = 1'b0;
    for (int i = 0; i < len; i++) begin
      ad = a + ADDR_W'(i);
      exp_q0.push_back(mem[ad]);
      exp_q1.push_back(mem[ad]);
      sum = sum + mem[ad];
    end
    exp_q0.push_back(sum);
    f0 = fin0;
    f1 = fin1;
    @(negedge clk);
    start_addr = a;
    length = LEN_W'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_fin(f0 + 1, f1 + 1, len * 60 + 200);
    repeat (5) @(negedge clk);
    chk("dut0_bytes_sent", 32'(if0.bytes_sent), 32'(len));
    chk("dut1_bytes_sent", 32'(if1.bytes_sent), 32'(len));
    chk("dut0_finished_once", 32'(fin0 - f0), 1);
    chk("dut1_finished_once", 32'(fin1 - f1), 1);
    chk("dut0_queue_drained", 32'(exp_q0.size()), 0);
    chk("dut1_queue_drained", 32'(exp_q1.size()), 0);
    chk("dut0_idle_after", 32'(if0.busy), 0);
  endtask

  initial begin
    int n;
    bit busy_seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_addr = '0; length = '0; tx_done = 1'b1; bus_data = 8'h00;
    for (int i = 0; i < int'(MEM_N); i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    do_dump(15'h0000, 4, 10);
    do_dump(15'h0123, 0, 10);
    chk("len0_no_bus_rd", 32'(rd_seen), 0);

    addr_log.delete();
    do_dump(15'h7FFE, 3, 10);
    chk("wrap_sample_count", 32'(addr_log.size()), 3);
    if (addr_log.size() == 3) begin
      chk("wrap_addr0", 32'(addr_log[0]), 32'h7FFE);
      chk("wrap_addr1", 32'(addr_log[1]), 32'h7FFF);
      chk("wrap_addr2", 32'(addr_log[2]), 32'h0000);
    end

    // abort while the second byte waits for the UART
    uart_hold = 60;
    exp_q0.push_back(mem[15'h0100]);
    exp_q1.push_back(mem[15'h0100]);
    n = fin0;
    last_tx0 = 0;
    @(negedge clk);
    start_addr = 15'h0100; length = LEN_W'(8); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && last_tx0 == 0; k++) @(negedge clk);
    chk("abort_first_tx_seen", 32'(last_tx0 > 0), 1);
    repeat (25) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_dut0_busy_low", 32'(if0.busy), 0);
    chk("abort_dut1_busy_low", 32'(if1.busy), 0);
    chk("abort_bus_rd_low", 32'(if0.bus_rd), 0);
    repeat (80) @(negedge clk);
    chk("abort_no_finished", 32'(fin0 - n), 0);
    chk("abort_dut0_bytes_sent", 32'(if0.bytes_sent), 1);
    chk("abort_dut1_bytes_sent", 32'(if1.bytes_sent), 1);
    chk("abort_queue_drained", 32'(exp_q0.size()), 0);
    do_dump(15'h0200, 3, 5);

    // reset mid-settle with start held high through release
    uart_hold = 10;
    @(negedge clk);
    start_addr = 15'h0300; length = LEN_W'(5); start = 1'b1;
    for (int k = 0; k < 20 && !if0.bus_rd; k++) @(negedge clk);
    chk("reset_test_in_settle", 32'(if0.bus_rd), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset("midreset");
    busy_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (if0.busy || if1.busy || if0.tx_valid) busy_seen = 1'b1;
    end
    chk("no_dump_with_start_held", 32'(busy_seen), 0);
    start = 1'b0;
    do_dump(15'h0300, 5, 10);

    for (int k = 0; k < 10; k++) begin
      logic [ADDR_W-1:0] ra;
      ra = (k % 3 == 0) ? ADDR_W'(15'h7FFC + 15'($urandom_range(0, 3))) : ADDR_W'($urandom);
      do_dump(ra, int'($urandom_range(0, 6)), int'($urandom_range(1, 12)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
